// File: rtl/step_stats_unit.sv
// ---------------------------------------------------------------------------
// step_stats_unit
//
// Consumes the step pulse generator's `pulse` and `clk_1hz` outputs. Both
// inputs are synchronised into the clk domain and edge detected. The unit
// then accumulates step statistics for the display/mux stage.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   pulse        in   step pulse train, one rising edge = one step
//   clk_1hz      in   1 Hz square wave, one rising edge = one second boundary
//   total_steps  out  saturating step count (14 bits)
//   saturated    out  high once total_steps has reached SAT_STEPS
//   distance     out  total_steps >> HALF_MILE_SHIFT, in half-miles
//   rate         out  steps counted in the last completed second
//   over32_secs  out  early seconds whose step count exceeded LOW_THRESH
//   high_run_max out  longest run of consecutive high-activity seconds
//   running      out  high while the FSM is in RUN
//
// Handshake: there is no valid/ready handshake. Each input rising edge is an
// event that is consumed exactly once, two clk edges after it is first
// sampled (two sync flops, then a registered edge strobe).
// ---------------------------------------------------------------------------
module step_stats_unit #(
    parameter int SAT_STEPS       = 9999,
    parameter int HALF_MILE_SHIFT = 10,
    parameter int LOW_THRESH      = 32,
    parameter int HIGH_THRESH     = 64,
    parameter int EARLY_WINDOW    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pulse,
    input  logic        clk_1hz,
    output logic [13:0] total_steps,
    output logic        saturated,
    output logic [3:0]  distance,
    output logic [7:0]  rate,
    output logic [3:0]  over32_secs,
    output logic [15:0] high_run_max,
    output logic        running
);

    typedef enum logic {
        ALIGN = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t      state;
    logic        p_s1, p_s2;
    logic        h_s1, h_s2;
    logic        step_ev;
    logic        sec_ev;
    logic [7:0]  win_cnt;
    logic [3:0]  sec_idx;
    logic [15:0] run_cur;
    logic [15:0] run_next;

    // Run length after the closing window is evaluated; high_run_max compares
    // against this so both update on the same edge.
    always_comb begin
        run_next = 16'd0;
        if (win_cnt >= 8'(HIGH_THRESH)) begin
            run_next = (run_cur == 16'hFFFF) ? run_cur : run_cur + 16'd1;
        end
    end

    assign distance = 4'(total_steps >> HALF_MILE_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ALIGN;
            p_s1         <= 1'b0;
            p_s2         <= 1'b0;
            h_s1         <= 1'b0;
            h_s2         <= 1'b0;
            step_ev      <= 1'b0;
            sec_ev       <= 1'b0;
            win_cnt      <= 8'd0;
            sec_idx      <= 4'd0;
            run_cur      <= 16'd0;
            total_steps  <= 14'd0;
            saturated    <= 1'b0;
            rate         <= 8'd0;
            over32_secs  <= 4'd0;
            high_run_max <= 16'd0;
            running      <= 1'b0;
        end else begin
            p_s1    <= pulse;
            p_s2    <= p_s1;
            h_s1    <= clk_1hz;
            h_s2    <= h_s1;
            // Registered one-cycle strobes; an input held high fires once.
            step_ev <= p_s1 & ~p_s2;
            sec_ev  <= h_s1 & ~h_s2;

            if (step_ev && (total_steps < 14'(SAT_STEPS))) begin
                total_steps <= total_steps + 14'd1;
                saturated   <= (total_steps == 14'(SAT_STEPS - 1));
            end

            case (state)
                ALIGN: begin
                    // Window is held empty until the first second boundary so
                    // the first reported rate covers a whole second.
                    win_cnt <= 8'd0;
                    if (sec_ev) begin
                        state   <= RUN;
                        running <= 1'b1;
                        sec_idx <= 4'd0;
                    end
                end
                RUN: begin
                    if (sec_ev) begin
                        rate <= win_cnt;
                        if ((sec_idx < 4'(EARLY_WINDOW)) && (win_cnt > 8'(LOW_THRESH))) begin
                            over32_secs <= over32_secs + 4'd1;
                        end
                        if (sec_idx < 4'(EARLY_WINDOW)) begin
                            sec_idx <= sec_idx + 4'd1;
                        end
                        run_cur <= run_next;
                        if (run_next > high_run_max) begin
                            high_run_max <= run_next;
                        end
                        // A coincident step belongs to the new window.
                        win_cnt <= step_ev ? 8'd1 : 8'd0;
                    end else if (step_ev && (win_cnt != 8'hFF)) begin
                        win_cnt <= win_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= ALIGN;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_stats_unit.sv
// ---------------------------------------------------------------------------
// tb_step_stats_unit
//
// Directed bench for step_stats_unit. Inputs change on the falling clk edge;
// outputs are sampled on the falling edge after events have settled.
// ---------------------------------------------------------------------------
module tb_step_stats_unit;

    logic        clk;
    logic        rst;
    logic        pulse;
    logic        clk_1hz;
    logic [13:0] total_steps;
    logic        saturated;
    logic [3:0]  distance;
    logic [7:0]  rate;
    logic [3:0]  over32_secs;
    logic [15:0] high_run_max;
    logic        running;

    int n_cmp = 0;
    int n_err = 0;

    step_stats_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pulse        (pulse),
        .clk_1hz      (clk_1hz),
        .total_steps  (total_steps),
        .saturated    (saturated),
        .distance     (distance),
        .rate         (rate),
        .over32_secs  (over32_secs),
        .high_run_max (high_run_max),
        .running      (running)
    );

    // Clock / reset: posedge at 5, 15, ...; negedge at 10, 20, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); pulse = 1'b1;
            repeat (2) @(negedge clk);
            pulse = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic sec_edge();
        @(negedge clk); clk_1hz = 1'b1;
        repeat (2) @(negedge clk);
        clk_1hz = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic both_edge();
        @(negedge clk); pulse = 1'b1; clk_1hz = 1'b1;
        repeat (2) @(negedge clk);
        pulse = 1'b0; clk_1hz = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_total"}, 32'(total_steps), 32'd0);
        chk({tag, "_sat"},   32'(saturated),   32'd0);
        chk({tag, "_dist"},  32'(distance),    32'd0);
        chk({tag, "_rate"},  32'(rate),        32'd0);
        chk({tag, "_o32"},   32'(over32_secs), 32'd0);
        chk({tag, "_hrm"},   32'(high_run_max),32'd0);
        chk({tag, "_run"},   32'(running),     32'd0);
    endtask

    initial begin
        rst = 1'b1; pulse = 1'b0; clk_1hz = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // ALIGN: steps count, no statistics
        step_n(5);
        chk("align_total", 32'(total_steps), 32'd5);
        chk("align_run",   32'(running),     32'd0);
        chk("align_rate",  32'(rate),        32'd0);

        // First second boundary only enters RUN
        sec_edge();
        chk("enter_run",  32'(running), 32'd1);
        chk("enter_rate", 32'(rate),    32'd0);

        // Nine early seconds of 40 steps
        for (int s = 0; s < 9; s++) begin
            step_n(40);
            sec_edge();
        end
        chk("early_o32",  32'(over32_secs), 32'd9);
        chk("early_rate", 32'(rate),        32'd40);
        chk("early_hrm",  32'(high_run_max),32'd0);
        step_n(40);
        sec_edge();
        chk("tenth_o32",   32'(over32_secs), 32'd9);
        chk("tenth_total", 32'(total_steps), 32'd405);

        // High run: 70,70,70,10,70,70 -> max 1,2,3,3,3,3
        step_n(70); sec_edge(); chk("hr1", 32'(high_run_max), 32'd1);
        step_n(70); sec_edge(); chk("hr2", 32'(high_run_max), 32'd2);
        step_n(70); sec_edge(); chk("hr3", 32'(high_run_max), 32'd3);
        step_n(10); sec_edge(); chk("hr4", 32'(high_run_max), 32'd3);
        chk("hr4_rate", 32'(rate), 32'd10);
        step_n(70); sec_edge(); chk("hr5", 32'(high_run_max), 32'd3);
        step_n(70); sec_edge(); chk("hr6", 32'(high_run_max), 32'd3);
        chk("hr_total", 32'(total_steps), 32'd765);

        // Simultaneous step and second edges
        step_n(5);
        both_edge();
        chk("sim_rate",  32'(rate),        32'd5);
        chk("sim_total", 32'(total_steps), 32'd771);
        step_n(2);
        sec_edge();
        chk("sim_next_rate", 32'(rate),        32'd3);
        chk("sim_next_total",32'(total_steps), 32'd773);

        // Thresholds inside the early window
        do_reset();
        sec_edge();
        step_n(32); sec_edge();
        chk("b32_rate", 32'(rate),        32'd32);
        chk("b32_o32",  32'(over32_secs), 32'd0);
        step_n(33); sec_edge();
        chk("b33_o32",  32'(over32_secs), 32'd1);
        step_n(63); sec_edge();
        chk("b63_hrm",  32'(high_run_max),32'd0);
        step_n(64); sec_edge();
        chk("b64_hrm",  32'(high_run_max),32'd1);
        chk("b64_o32",  32'(over32_secs), 32'd3);

        // Saturation and distance
        do_reset();
        step_n(1023);
        chk("dist_1023", 32'(distance), 32'd0);
        step_n(1);
        chk("dist_1024", 32'(distance), 32'd1);
        step_n(9998 - 1024);
        chk("sat_9998_total", 32'(total_steps), 32'd9998);
        chk("sat_9998_flag",  32'(saturated),   32'd0);
        step_n(12);
        chk("sat_total", 32'(total_steps), 32'd9999);
        chk("sat_flag",  32'(saturated),   32'd1);
        chk("sat_dist",  32'(distance),    32'd9);

        // Mid-operation asynchronous reset
        do_reset();
        step_n(100);
        sec_edge();
        step_n(70);
        sec_edge();
        chk("pre_rst_rate", 32'(rate), 32'd70);
        step_n(330);
        chk("pre_rst_total", 32'(total_steps), 32'd500);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk); rst = 1'b0;
        sec_edge();
        chk("post_rst_run",  32'(running), 32'd1);
        chk("post_rst_rate", 32'(rate),    32'd0);
        step_n(3);
        sec_edge();
        chk("post_rst_rate2", 32'(rate), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
